hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage core (F/D/E/M/W). Each cycle it takes
//  the decode stage's GRF read/write descriptors and tracks in-flight writers in
//  shadow registers for E, M and W. From these it drives the stall/bubble signal
//  and the forwarding selects used by the D, E and M operand muxes.
// PARAMETERS
//  ADDR_W   5   GRF address width
//  CNT_W    32  width of the stall performance counter
// PORTS
//  clk              in   1       core clock; all state updates on rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  d_read_addr0     in   ADDR_W  rs address of instruction in D
//  d_read_addr1     in   ADDR_W  rt address of instruction in D
//  d_read_stage0    in   2       stage needing rs: 0=D 1=E 2=M 3=never (`STAGE_*)
//  d_read_stage1    in   2       stage needing rt, same encoding
//  d_write_addr     in   ADDR_W  destination of D instruction; 0 = no write
//  d_write_stage    in   2       stage at whose end the result exists (0=D 1=E 2=M)
//  stall            out  1       1: hold PC and F/D register, insert bubble into E
//  fwd_d0, fwd_d1   out  2       D operand source: 0=GRF 1=E reg 2=M reg 3=W reg
//  fwd_e0, fwd_e1   out  2       E operand source: 0=pipe reg 2=M reg 3=W reg
//  fwd_m1           out  2       M store-data source: 0=pipe reg 3=W reg
//  stall_count      out  CNT_W   number of stall cycles since reset, saturating
// BEHAVIOUR
//  State: shadow E{waddr,wstage,raddr0,raddr1,rstage0,rstage1}, M{waddr,wstage,raddr1,
//   rstage1}, W{waddr,wstage}, stall_count. rst_n low clears all of it at once:
//   waddr=0, and therefore stall=0, all fwd_*=0, stall_count=0.
//  Shift each edge: W<=M, M<=E. E<=D descriptors when stall=0. When stall=1, E is
//   loaded with a bubble (all fields 0, rstage=3).
//  Stage index X: E=1, M=2, W=3. A writer at X with write stage s and addr a!=0
//   "has value" iff s < X.
//  Stall (combinational, from current D and shadow): for operand k with
//   rstage_k!=3 and addr_k!=0, any shadow writer at X with waddr==addr_k and
//   s >= X + rstage_k -> stall=1. Writers at W never stall. Address 0 never stalls.
//  Forward select for consumer operand at stage Y (D=0,E=1,M=2): nearest producer
//   with X>Y, waddr==addr!=0 and value present (s < X); the youngest match wins
//   (E over M over W). If the nearest match has no value, select 0. That case only
//   occurs when stall=1, or when the operand is not needed at Y.
//  fwd_d* are evaluated against E/M/W, fwd_e* against M/W using shadow-E read
//   addresses, and fwd_m1 against W using shadow-M raddr1. fwd_e*/fwd_m1 are
//   forced to 0 when the matching rstage is 3.
//  The W-stage forward is mandatory. The GRF gives no same-cycle write-through guarantee.
//  stall_count increments on every cycle with stall=1 and saturates at all-ones.
//  Latency: stall and fwd_* are purely combinational from inputs and state. There
//   is no added cycle.
//  An asserted reset during a stall drops stall the same cycle. The first
//   post-reset D instruction sees an empty pipeline.
// TESTING
//  addu $1 then beq $1,$1: cycle1 stall=1; cycle2 stall=0, fwd_d0=fwd_d1=2 (M).
//  lw $2 then addu $3,$2,$0: 1 stall. Then, with addu in E and lw in W, fwd_e0=3.
//  lw $4 then jr $4: 2 consecutive stall cycles, then fwd_d0=3; stall_count=2.
//  jal then jr $31 back-to-back: stall=0, fwd_d0=1 (value from E reg).
//  ori $0 then addu $5,$0,$0: stall=0, all fwd=0. lw $6 then sw $6,0($7): no
//   stall, fwd_m1=3.
//  lw $8 then beq $8 with rst_n pulsed low mid-stall: stall=0 and stall_count=0
//   immediately, and shadows are empty after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Decode-to-hazard-controller bundle: the D-stage GRF descriptors going in,
// the stall, forwarding selects and stall counter coming back out.
interface hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] d_read_addr0;
  logic [ADDR_W-1:0] d_read_addr1;
  logic [1:0]        d_read_stage0;
  logic [1:0]        d_read_stage1;
  logic [ADDR_W-1:0] d_write_addr;
  logic [1:0]        d_write_stage;

  logic              stall;
  logic [1:0]        fwd_d0;
  logic [1:0]        fwd_d1;
  logic [1:0]        fwd_e0;
  logic [1:0]        fwd_e1;
  logic [1:0]        fwd_m1;
  logic [CNT_W-1:0]  stall_count;

  // Pipeline side: presents decode descriptors, consumes hazard decisions.
  modport master (
    output d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
           d_write_addr, d_write_stage,
    input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, stall_count
  );

  // Controller side.
  modport slave (
    input  d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
           d_write_addr, d_write_stage,
    output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage F/D/E/M/W core. Shadows the writer and
// reader descriptors of the instructions in E, M and W, and from them derives
// the stall/bubble request and the operand forwarding selects for D, E and M.
// Stage numbering: D=0, E=1, M=2, W=3; a read stage of 3 means "never read".
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] STAGE_NEVER = 2'd3;

  localparam logic [1:0] SRC_PIPE = 2'd0;
  localparam logic [1:0] SRC_E    = 2'd1;
  localparam logic [1:0] SRC_M    = 2'd2;
  localparam logic [1:0] SRC_W    = 2'd3;

  // Shadow of the instruction currently in E
  logic [ADDR_W-1:0] e_waddr;
  logic [1:0]        e_wstage;
  logic [ADDR_W-1:0] e_raddr0;
  logic [ADDR_W-1:0] e_raddr1;
  logic [1:0]        e_rstage0;
  logic [1:0]        e_rstage1;

  // Shadow of the instruction in M (only rt matters there: store data)
  logic [ADDR_W-1:0] m_waddr;
  logic [1:0]        m_wstage;
  logic [ADDR_W-1:0] m_raddr1;
  logic [1:0]        m_rstage1;

  // Shadow of the instruction in W
  logic [ADDR_W-1:0] w_waddr;
  logic [1:0]        w_wstage;

  logic [CNT_W-1:0]  stall_count;
  logic              stall;
  logic              stall_op0;
  logic              stall_op1;
  logic [1:0]        fwd_d0;
  logic [1:0]        fwd_d1;
  logic [1:0]        fwd_e0;
  logic [1:0]        fwd_e1;
  logic [1:0]        fwd_m1;

  // A writer sitting at stage x has its result latched once its write stage
  // is strictly earlier than x.
  function automatic logic has_value(input logic [1:0] wstage, input logic [2:0] x);
    return {1'b0, wstage} < x;
  endfunction

  // A D operand must wait for a writer at stage x if the writer's result
  // cannot be ready by the time the operand is consumed.
  function automatic logic blocks(input logic [ADDR_W-1:0] addr,
                                  input logic [1:0]        rstage,
                                  input logic [ADDR_W-1:0] waddr,
                                  input logic [1:0]        wstage,
                                  input logic [2:0]        x);
    return (rstage != STAGE_NEVER) && (addr != '0) && (waddr == addr) &&
           ({1'b0, wstage} >= (x + {1'b0, rstage}));
  endfunction

  // Youngest matching producer wins; if that producer has no value yet the
  // consumer keeps its own pipe value (the stall logic covers real needs).
  // Stages that must not be considered are passed with a zero address.
  function automatic logic [1:0] pick_src(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] ea,
                                          input logic [1:0]        es,
                                          input logic [ADDR_W-1:0] ma,
                                          input logic [1:0]        ms,
                                          input logic [ADDR_W-1:0] wa,
                                          input logic [1:0]        ws);
    logic [1:0] src;
    src = SRC_PIPE;
    if (addr != '0) begin
      if (ea == addr)      src = has_value(es, 3'd1) ? SRC_E : SRC_PIPE;
      else if (ma == addr) src = has_value(ms, 3'd2) ? SRC_M : SRC_PIPE;
      else if (wa == addr) src = has_value(ws, 3'd3) ? SRC_W : SRC_PIPE;
    end
    return src;
  endfunction

  // Stall decision for the instruction in D against in-flight writers in E and M
  always_comb begin
    stall_op0 = blocks(hz.d_read_addr0, hz.d_read_stage0, e_waddr, e_wstage, 3'd1) ||
                blocks(hz.d_read_addr0, hz.d_read_stage0, m_waddr, m_wstage, 3'd2);
    stall_op1 = blocks(hz.d_read_addr1, hz.d_read_stage1, e_waddr, e_wstage, 3'd1) ||
                blocks(hz.d_read_addr1, hz.d_read_stage1, m_waddr, m_wstage, 3'd2);
    stall     = stall_op0 || stall_op1;
  end

  // Forwarding selects for the D, E and M operand muxes
  always_comb begin
    fwd_d0 = pick_src(hz.d_read_addr0, e_waddr, e_wstage, m_waddr, m_wstage, w_waddr, w_wstage);
    fwd_d1 = pick_src(hz.d_read_addr1, e_waddr, e_wstage, m_waddr, m_wstage, w_waddr, w_wstage);
    fwd_e0 = SRC_PIPE;
    fwd_e1 = SRC_PIPE;
    fwd_m1 = SRC_PIPE;
    if (e_rstage0 != STAGE_NEVER)
      fwd_e0 = pick_src(e_raddr0, '0, 2'd0, m_waddr, m_wstage, w_waddr, w_wstage);
    if (e_rstage1 != STAGE_NEVER)
      fwd_e1 = pick_src(e_raddr1, '0, 2'd0, m_waddr, m_wstage, w_waddr, w_wstage);
    if (m_rstage1 != STAGE_NEVER)
      fwd_m1 = pick_src(m_raddr1, '0, 2'd0, '0, 2'd0, w_waddr, w_wstage);
  end

  // Advance the shadow pipeline; a stall injects a bubble into E.
  // Reset leaves every stage holding a bubble so the next D sees an empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_waddr   <= '0;
      e_wstage  <= 2'd0;
      e_raddr0  <= '0;
      e_raddr1  <= '0;
      e_rstage0 <= STAGE_NEVER;
      e_rstage1 <= STAGE_NEVER;
      m_waddr   <= '0;
      m_wstage  <= 2'd0;
      m_raddr1  <= '0;
      m_rstage1 <= STAGE_NEVER;
      w_waddr   <= '0;
      w_wstage  <= 2'd0;
    end else begin
      w_waddr   <= m_waddr;
      w_wstage  <= m_wstage;
      m_waddr   <= e_waddr;
      m_wstage  <= e_wstage;
      m_raddr1  <= e_raddr1;
      m_rstage1 <= e_rstage1;
      if (stall) begin
        e_waddr   <= '0;
        e_wstage  <= 2'd0;
        e_raddr0  <= '0;
        e_raddr1  <= '0;
        e_rstage0 <= STAGE_NEVER;
        e_rstage1 <= STAGE_NEVER;
      end else begin
        e_waddr   <= hz.d_write_addr;
        e_wstage  <= hz.d_write_stage;
        e_raddr0  <= hz.d_read_addr0;
        e_raddr1  <= hz.d_read_addr1;
        e_rstage0 <= hz.d_read_stage0;
        e_rstage1 <= hz.d_read_stage1;
      end
    end
  end

  // Saturating count of stall cycles since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

  assign hz.stall       = stall;
  assign hz.fwd_d0      = fwd_d0;
  assign hz.fwd_d1      = fwd_d1;
  assign hz.fwd_e0      = fwd_e0;
  assign hz.fwd_e1      = fwd_e1;
  assign hz.fwd_m1      = fwd_m1;
  assign hz.stall_count = stall_count;

endmodule
